miter_result_monitor: RTL
=========================

// Module: miter_result_monitor
// PURPOSE
//  Sequential checker downstream of the equivalence miter: samples the two design-under-compare outputs y_1/y_2 every clock.
//  Ignores a warm-up window, then counts mismatches over a fixed run and latches the first failing cycle and bit-diff.
//  Reports sticky pass/fail for simulation benches and for an on-board harness where formal assert is unavailable.
// PARAMETERS
//  WIDTH    91  compared output width (matches miter y_1/y_2 [90:0])
//  WARMUP   4   cycles after start before comparison begins (0 = compare from first cycle)
//  RUN_LEN  256 compared cycles per run; 1 <= RUN_LEN < 2**CNT_W
//  CNT_W    16  width of cycle and mismatch counters
// PORTS
//  clk           in   1      rising-edge clock, same clock as the miter
//  rst_n         in   1      synchronous active-low reset
//  start         in   1      begin a run (honoured in IDLE and DONE only)
//  y_1           in   WIDTH  output of implementation 1
//  y_2           in   WIDTH  output of implementation 2
//  busy          out  1      high in WARMUP and CHECK
//  done          out  1      high in DONE
//  fail          out  1      sticky: at least one mismatch this run
//  mismatch_cnt  out  CNT_W  mismatching compared cycles, saturates at all-ones
//  first_cycle   out  CNT_W  compare-cycle index (0-based) of first mismatch
//  first_diff    out  WIDTH  y_1 ^ y_2 captured at first mismatch
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): state=IDLE; all outputs 0; internal counters 0. Reset mid-run aborts, no residue.
//  - FSM: IDLE -start-> WARMUP (WARMUP>0) or CHECK (WARMUP==0); WARMUP -wcnt==WARMUP-1-> CHECK;
//    CHECK -ccnt==RUN_LEN-1-> DONE; DONE -start-> same as IDLE exit. No other transitions.
//  - Run start (accepted start): clears fail, mismatch_cnt, first_cycle, first_diff, wcnt, ccnt same edge.
//  - start in WARMUP/CHECK ignored; start held high in DONE restarts every time DONE is reached.
//  - WARMUP: y_* not compared; wcnt counts 0..WARMUP-1, exactly WARMUP cycles spent.
//  - CHECK: each cycle compares y_1 vs y_2 sampled at that edge; ccnt = 0..RUN_LEN-1, exactly RUN_LEN samples.
//    Mismatch -> fail=1 and mismatch_cnt+1 (saturating) visible the following cycle (1-cycle latency).
//    First mismatch only (fail was 0): first_cycle<=ccnt, first_diff<=y_1^y_2; later mismatches never overwrite.
//  - Sample on the last CHECK edge is counted; DONE and final stats appear together on the next cycle.
//  - DONE: counters/flags hold stable until next accepted start or reset.
//  - X on y_* in CHECK counts as mismatch (use !== semantics in sim; synthesis compares as ==).
//  - busy and done never both high; busy = (WARMUP|CHECK), done = (DONE), both registered state decodes.
// CONFIGURATION
//  MITER_MON_ASSERT_EN defined: an immediate assertion in the clocked block fires (error) on every CHECK-state
//    mismatch, reporting ccnt and y_1^y_2; also asserts mismatch_cnt never wraps.
//  Not defined: no assertions compiled; counting/capture behaviour identical.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with start=1 -> busy=done=fail=0, mismatch_cnt=0, state IDLE after release.
//  2 Clean run: WARMUP=4,RUN_LEN=8, y_1==y_2 always, pulse start -> busy high 12 cycles, done=1, fail=0, cnt=0.
//  3 Warm-up masking: y_1!=y_2 only in the 4 warm-up cycles -> fail=0, mismatch_cnt=0 at done.
//  4 Capture: y_2=y_1^(1<<90) at compare cycles 3 and 5 -> fail=1 from cycle after idx 3,
//    mismatch_cnt=2, first_cycle=3, first_diff=1<<90.
//  5 Saturation: CNT_W=4, RUN_LEN=15, permanent mismatch -> mismatch_cnt=15, first_cycle=0; no wrap.
//  6 Restart/abort: start in DONE clears stats same edge; rst_n=0 mid-CHECK -> IDLE, all outputs 0 next cycle.

Source files
------------

// File: rtl/miter_result_monitor.sv
// miter_result_monitor: sequential checker behind the equivalence miter.
// Skips a warm-up window, then compares y_1/y_2 for RUN_LEN cycles. It counts
// mismatching cycles (saturating) and latches the index and bit-diff of the
// first mismatch. fail stays high until the next run starts.
// Optional build macro: MITER_MON_ASSERT_EN enables immediate assertions that
// flag each CHECK-state mismatch and any mismatch-counter wrap.
module miter_result_monitor #(
    parameter int WIDTH   = 91,
    parameter int WARMUP  = 4,
    parameter int RUN_LEN = 256,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] y_1,
    input  logic [WIDTH-1:0] y_2,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_cycle,
    output logic [WIDTH-1:0] first_diff
);

    typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_CHECK, ST_DONE} state_t;

    // Terminal counter values. The WARMUP==0 case never enters ST_WARMUP,
    // so its terminal value is irrelevant and is clamped to 0.
    localparam logic [CNT_W-1:0] WLAST = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [CNT_W-1:0] CLAST = CNT_W'(RUN_LEN - 1);
    localparam state_t RUN_ENTRY = (WARMUP > 0) ? ST_WARMUP : ST_CHECK;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wcnt, ccnt, cnt_sat;
    logic [WIDTH-1:0] diff;
    logic             accept, mism;

    // Four-state compare: an X or Z bit on either side counts as a mismatch
    // in simulation. Synthesis reduces this to a plain inequality.
    assign diff    = y_1 ^ y_2;
    assign mism    = (y_1 !== y_2);
    assign accept  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign cnt_sat = (mismatch_cnt == '1) ? mismatch_cnt : mismatch_cnt + 1'b1;

    // Status outputs decode the registered state directly.
    assign busy = (state == ST_WARMUP) || (state == ST_CHECK);
    assign done = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. start is ignored while a run is in progress.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = RUN_ENTRY;
            ST_WARMUP: if (wcnt == WLAST) state_nxt = ST_CHECK;
            ST_CHECK:  if (ccnt == CLAST) state_nxt = ST_DONE;
            ST_DONE:   if (start) state_nxt = RUN_ENTRY;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Counters and capture. A new run clears all stats on the accepting edge.
    // In DONE, every value holds until the next start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt         <= '0;
            ccnt         <= '0;
            fail         <= 1'b0;
            mismatch_cnt <= '0;
            first_cycle  <= '0;
            first_diff   <= '0;
        end else if (accept) begin
            wcnt         <= '0;
            ccnt         <= '0;
            fail         <= 1'b0;
            mismatch_cnt <= '0;
            first_cycle  <= '0;
            first_diff   <= '0;
        end else begin
`ifdef MITER_MON_ASSERT_EN
            if (state == ST_CHECK) begin
                assert (!mism)
                    else $error("miter mismatch at compare cycle %0d diff %h", ccnt, diff);
                assert (!mism || (cnt_sat >= mismatch_cnt))
                    else $error("mismatch_cnt wrapped at compare cycle %0d", ccnt);
            end
`endif
            case (state)
                ST_WARMUP: begin
                    if (wcnt != WLAST) wcnt <= wcnt + 1'b1;
                end
                ST_CHECK: begin
                    if (ccnt != CLAST) ccnt <= ccnt + 1'b1;
                    if (mism) begin
                        fail         <= 1'b1;
                        mismatch_cnt <= cnt_sat;
                        // Only the first mismatch of a run is recorded.
                        if (!fail) begin
                            first_cycle <= ccnt;
                            first_diff  <= diff;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
